// File: rtl/alu_pipe.sv
// Three-stage fixed-point MAC: a*b +/- c*d +/- e with Q-format coefficients b/d,
// round-half-up rescaling, optional saturation and a stall-together valid/ready pipe.
module alu_pipe #(
    parameter int BUS_WIDTH = 8,
    parameter int FRAC_BITS = 7,
    parameter int SATURATE  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [4:0][BUS_WIDTH-1:0]     ops,
    input  logic [1:0]                    mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BUS_WIDTH-1:0]          result,
    output logic                          overflow
);

    localparam int PW    = 2*BUS_WIDTH + 1;
    localparam int SW    = 2*BUS_WIDTH + 2;
    localparam int RND_I = (2**FRAC_BITS) / 2;

    localparam logic signed [PW-1:0] RND  = PW'(RND_I);
    localparam logic signed [SW-1:0] MAXV = SW'((2**(BUS_WIDTH-1)) - 1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    logic                          w_en;

    logic                          r_s1_valid;
    logic [4:0][BUS_WIDTH-1:0]     r_s1_ops;
    logic [1:0]                    r_s1_mode;

    logic                          r_s2_valid;
    logic signed [PW-1:0]          r_s2_pab;
    logic signed [PW-1:0]          r_s2_pcd;
    logic [BUS_WIDTH-1:0]          r_s2_e;
    logic [1:0]                    r_s2_mode;

    logic                          r_out_valid;
    logic [BUS_WIDTH-1:0]          r_result;
    logic                          r_overflow;

    logic signed [PW-1:0]          w_a, w_b, w_c, w_d;
    logic signed [PW-1:0]          w_prod_ab, w_prod_cd;
    logic signed [PW-1:0]          w_pab, w_pcd;
    logic signed [SW-1:0]          w_pab_x, w_pcd_x, w_e_x;
    logic signed [SW-1:0]          w_sum;
    logic                          w_ovf;
    logic [BUS_WIDTH-1:0]          w_res;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign w_en      = !r_out_valid || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;

    assign w_a = PW'($signed(r_s1_ops[0]));
    assign w_b = PW'($signed(r_s1_ops[1]));
    assign w_c = PW'($signed(r_s1_ops[2]));
    assign w_d = PW'($signed(r_s1_ops[3]));

    assign w_prod_ab = w_a * w_b;
    assign w_prod_cd = w_c * w_d;
    // Arithmetic shift after adding half an LSB rounds ties toward +inf.
    assign w_pab     = (w_prod_ab + RND) >>> FRAC_BITS;
    assign w_pcd     = (w_prod_cd + RND) >>> FRAC_BITS;

    assign w_pab_x = SW'(r_s2_pab);
    assign w_pcd_x = SW'(r_s2_pcd);
    assign w_e_x   = SW'($signed(r_s2_e));

    always_comb begin
        w_sum = '0;
        case (r_s2_mode)
            2'b00:   w_sum = w_pab_x + w_pcd_x + w_e_x;
            2'b01:   w_sum = w_pab_x - w_pcd_x + w_e_x;
            2'b10:   w_sum = w_e_x - (w_pab_x + w_pcd_x);
            default: w_sum = w_pab_x + w_pcd_x;
        endcase
    end

    always_comb begin
        w_ovf = (w_sum > MAXV) || (w_sum < MINV);
        w_res = w_sum[BUS_WIDTH-1:0];
        if (w_ovf && (SATURATE != 0)) begin
            w_res = (w_sum > MAXV) ? MAXV[BUS_WIDTH-1:0] : MINV[BUS_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_ops    <= '0;
            r_s1_mode   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_pab    <= '0;
            r_s2_pcd    <= '0;
            r_s2_e      <= '0;
            r_s2_mode   <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
        end else if (w_en) begin
            r_s1_valid  <= in_valid;
            r_s1_ops    <= ops;
            r_s1_mode   <= mode;
            r_s2_valid  <= r_s1_valid;
            r_s2_pab    <= w_pab;
            r_s2_pcd    <= w_pcd;
            r_s2_e      <= r_s1_ops[4];
            r_s2_mode   <= r_s1_mode;
            r_out_valid <= r_s2_valid;
            r_result    <= w_res;
            r_overflow  <= w_ovf;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: saturating Q7 unit plus wrapping and integer variants
// driven in lockstep from the same inputs.
module tb_alu_pipe;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [4:0][7:0]  ops;
    logic [1:0]       mode;
    logic             out_ready;

    logic             in_ready,   out_valid,   overflow;
    logic [7:0]       result;
    logic             in_ready_w, out_valid_w, overflow_w;
    logic [7:0]       result_w;
    logic             in_ready_i, out_valid_i, overflow_i;
    logic [7:0]       result_i;

    int total = 0;
    int bad   = 0;

    alu_pipe #(.BUS_WIDTH(8), .FRAC_BITS(7), .SATURATE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ops(ops), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow)
    );

    alu_pipe #(.BUS_WIDTH(8), .FRAC_BITS(7), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .ops(ops), .mode(mode), .out_valid(out_valid_w), .out_ready(out_ready),
        .result(result_w), .overflow(overflow_w)
    );

    alu_pipe #(.BUS_WIDTH(8), .FRAC_BITS(0), .SATURATE(1)) u_int (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_i),
        .ops(ops), .mode(mode), .out_valid(out_valid_i), .out_ready(out_ready),
        .result(result_i), .overflow(overflow_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Presents one vector, waits (bounded) for it at the output; lat counts edges
    // from the accepting edge up to the one that raises out_valid.
    task automatic run_vec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input logic [7:0] e, input logic [1:0] m,
                           output int lat);
        ops       = {e, d, c, b, a};
        mode      = m;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ops = '0; mode = 2'b00;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h exp=00", result); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mode_sweep;
        logic [7:0] exp_r [4];
        int lat;
        exp_r[0] = 8'h2D; exp_r[1] = 8'h41; exp_r[2] = 8'hDD; exp_r[3] = 8'h28;
        for (int m = 0; m < 4; m++) begin
            run_vec(8'd100, 8'h40, 8'hEC, 8'h40, 8'd5, 2'(m), lat);
            total++; if (lat !== 3) begin bad++; $display("FAIL mode%0d_latency got=%0d exp=3", m, lat); end
            total++; if (result !== exp_r[m]) begin bad++; $display("FAIL mode%0d_result got=%h exp=%h", m, result, exp_r[m]); end
            total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mode%0d_overflow got=%0b exp=0", m, overflow); end
        end
    endtask

    task automatic test_rounding;
        int lat;
        run_vec(8'd3, 8'h40, 8'h00, 8'h00, 8'h00, 2'b00, lat);
        total++; if (result !== 8'h02) begin bad++; $display("FAIL round_pos got=%h exp=02", result); end
        run_vec(8'hFD, 8'h40, 8'h00, 8'h00, 8'h00, 2'b00, lat);
        total++; if (result !== 8'hFF) begin bad++; $display("FAIL round_neg got=%h exp=ff", result); end
    endtask

    task automatic test_saturation;
        int lat;
        run_vec(8'h80, 8'h80, 8'h80, 8'h80, 8'd127, 2'b00, lat);
        total++; if (result !== 8'h7F) begin bad++; $display("FAIL sat_hi_result got=%h exp=7f", result); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL sat_hi_overflow got=%0b exp=1", overflow); end
        total++; if (result_w !== 8'h7F) begin bad++; $display("FAIL wrap_383_result got=%h exp=7f", result_w); end
        total++; if (overflow_w !== 1'b1) begin bad++; $display("FAIL wrap_383_overflow got=%0b exp=1", overflow_w); end
        run_vec(8'h80, 8'h80, 8'h80, 8'h80, 8'd127, 2'b10, lat);
        total++; if (result !== 8'h80) begin bad++; $display("FAIL sat_lo_result got=%h exp=80", result); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL sat_lo_overflow got=%0b exp=1", overflow); end
        run_vec(8'h80, 8'h80, 8'h80, 8'h80, 8'd0, 2'b00, lat);
        total++; if (result_w !== 8'h00) begin bad++; $display("FAIL wrap_256_result got=%h exp=00", result_w); end
        total++; if (overflow_w !== 1'b1) begin bad++; $display("FAIL wrap_256_overflow got=%0b exp=1", overflow_w); end
        total++; if (result !== 8'h7F) begin bad++; $display("FAIL sat_256_result got=%h exp=7f", result); end
    endtask

    task automatic test_integer;
        int lat;
        run_vec(8'd5, 8'hFD, 8'd2, 8'd4, 8'd1, 2'b00, lat);
        total++; if (result_i !== 8'hFA) begin bad++; $display("FAIL int_result got=%h exp=fa", result_i); end
        total++; if (overflow_i !== 1'b0) begin bad++; $display("FAIL int_overflow got=%0b exp=0", overflow_i); end
        total++; if (out_valid_i !== 1'b1) begin bad++; $display("FAIL int_out_valid got=%0b exp=1", out_valid_i); end
    endtask

    task automatic test_back_to_back;
        int  sent  = 0;
        int  got   = 0;
        int  stall = 0;
        bit  acc;
        // Drain anything left from earlier tests.
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (sent < 4) begin
                ops = {8'd0, 8'd0, 8'd0, 8'h7F, 8'(sent + 1)};
                mode = 2'b11;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (stall >= 3);
            #1;
            acc = in_valid && in_ready;
            if (out_valid && !out_ready) begin
                stall++;
                total++; if (result !== 8'h01) begin bad++; $display("FAIL stall_hold_result got=%h exp=01", result); end
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%0b exp=0", in_ready); end
            end
            if (out_valid && out_ready) begin
                total++; if (result !== 8'(got + 1)) begin bad++; $display("FAIL b2b_order got=%h exp=%h", result, 8'(got + 1)); end
                got++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (got !== 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", got); end
        total++; if (stall !== 3) begin bad++; $display("FAIL b2b_stall_cycles got=%0d exp=3", stall); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_dup got=%0b exp=0", out_valid); end
    endtask

    task automatic test_reset_midstream;
        ops = {8'd0, 8'd0, 8'd0, 8'h40, 8'd100};
        mode = 2'b11; in_valid = 1'b1; out_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || result !== 8'd50) begin bad++; $display("FAIL rst_pre_out got=%0b/%h exp=1/32", out_valid, result); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got=%0b exp=0", out_valid); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL rst_async_result got=%h exp=00", result); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_async_overflow got=%0b exp=0", overflow); end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_post_idle cyc=%0d got=%0b exp=0", i, out_valid); end
        end
    endtask

    initial begin
        test_reset;
        test_mode_sweep;
        test_rounding;
        test_saturation;
        test_integer;
        test_back_to_back;
        test_reset_midstream;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
